// File: rtl/efuse_load_ctrl.sv
// Post-reset eFuse shadow loader: reads each eFuse word and writes it into its trim register
// through the logic-write port, then checks the trailing XOR checksum word.
module efuse_load_ctrl #(
  parameter int unsigned DW           = 8,
  parameter int unsigned EFUSE_WORDS  = 8,
  parameter int unsigned EAW          = 3,
  parameter int unsigned RD_PULSE_CYC = 4,
  parameter bit          AUTO_LOAD    = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load_req,
  output logic                   o_efuse_ren,
  output logic [EAW-1:0]         o_efuse_addr,
  input  logic [DW-1:0]          i_efuse_rdata,
  output logic                   o_efuse_ctrl_reg_en,
  output logic [EFUSE_WORDS-1:0] o_lgc_wen,
  output logic [DW-1:0]          o_lgc_wdata,
  output logic                   o_load_busy,
  output logic                   o_load_done,
  output logic                   o_chk_err
);

  localparam int unsigned             CW      = (RD_PULSE_CYC > 1) ? $clog2(RD_PULSE_CYC) : 1;
  localparam logic [CW-1:0]           CntLast = CW'(RD_PULSE_CYC - 1);
  localparam logic [EAW-1:0]          IdxLast = EAW'(EFUSE_WORDS - 1);
  localparam logic [EFUSE_WORDS-1:0]  WenOne  = EFUSE_WORDS'(1);

  typedef enum logic [2:0] {StIdle, StStrobe, StCapture, StWrite, StFinish} state_e;

  state_e          state_q;
  logic [EAW-1:0]  idx_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   cap_q;
  logic [DW-1:0]   acc_q;
  logic            pend_q;

  // Address comes straight from the index register, so it is stable through strobe and capture.
  assign o_efuse_addr        = idx_q;
  assign o_efuse_ctrl_reg_en = o_load_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      cap_q       <= '0;
      acc_q       <= '0;
      pend_q      <= AUTO_LOAD;
      o_efuse_ren <= 1'b0;
      o_lgc_wen   <= '0;
      o_lgc_wdata <= '0;
      o_load_busy <= 1'b0;
      o_load_done <= 1'b0;
      o_chk_err   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pend_q || i_load_req) begin
            state_q     <= StStrobe;
            pend_q      <= 1'b0;
            o_load_done <= 1'b0;
            o_chk_err   <= 1'b0;
            idx_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            o_efuse_ren <= 1'b1;
            o_load_busy <= 1'b1;
          end
        end
        StStrobe: begin
          if (cnt_q == CntLast) begin
            o_efuse_ren <= 1'b0;
            state_q     <= StCapture;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StCapture: begin
          cap_q       <= i_efuse_rdata;
          o_lgc_wdata <= i_efuse_rdata;
          o_lgc_wen   <= WenOne << idx_q;
          state_q     <= StWrite;
        end
        StWrite: begin
          o_lgc_wen <= '0;
          if (idx_q != IdxLast) begin
            acc_q       <= acc_q ^ cap_q;
            idx_q       <= idx_q + EAW'(1);
            cnt_q       <= '0;
            o_efuse_ren <= 1'b1;
            state_q     <= StStrobe;
          end else begin
            // Last word is the checksum: it must equal the XOR of all preceding words.
            o_chk_err   <= (acc_q != cap_q);
            o_load_busy <= 1'b0;
            state_q     <= StFinish;
          end
        end
        StFinish: begin
          o_load_done <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_efuse_load_ctrl.sv
// Directed bench for efuse_load_ctrl: table of eFuse images with expected checksum result,
// plus hand-written sequences for ignored requests, mid-load reset and AUTO_LOAD = 0.
module tb_efuse_load_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_req, load_req2;
  logic       ren, ren2;
  logic [2:0] addr, addr2;
  logic [7:0] rdata, rdata2;
  logic       ctrl_en, ctrl_en2;
  logic [7:0] wen, wen2;
  logic [7:0] wdata, wdata2;
  logic       busy, busy2, done, done2, err, err2;

  always #5 clk = ~clk;

  efuse_load_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_req(load_req), .o_efuse_ren(ren),
    .o_efuse_addr(addr), .i_efuse_rdata(rdata), .o_efuse_ctrl_reg_en(ctrl_en),
    .o_lgc_wen(wen), .o_lgc_wdata(wdata), .o_load_busy(busy), .o_load_done(done),
    .o_chk_err(err)
  );

  efuse_load_ctrl #(.AUTO_LOAD(1'b0)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_req(load_req2), .o_efuse_ren(ren2),
    .o_efuse_addr(addr2), .i_efuse_rdata(rdata2), .o_efuse_ctrl_reg_en(ctrl_en2),
    .o_lgc_wen(wen2), .o_lgc_wdata(wdata2), .o_load_busy(busy2), .o_load_done(done2),
    .o_chk_err(err2)
  );

  // eFuse model: data only valid in the last strobe cycle and the cycle after it.
  logic [63:0] cur_words, mem2;
  int          ren_run;
  logic        prev_ren_m;
  always @(posedge clk) begin
    ren_run    <= ren ? ren_run + 1 : 0;
    prev_ren_m <= ren;
  end
  assign rdata  = ((ren && ren_run == 3) || (!ren && prev_ren_m)) ?
                  cur_words[int'(addr)*8 +: 8] : 8'hEE;
  assign rdata2 = mem2[int'(addr2)*8 +: 8];

  typedef struct packed {
    logic [63:0] words;
    logic        exp_err;
  } vec_t;
  vec_t vecs [4];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor state for dut
  int         cyc = 0;
  int         wr_cyc[$];
  logic [7:0] wr_wen[$], wr_dat[$];
  int         run_addr_q[$], run_len_q[$];
  logic       run_ok_q[$];
  int         run_len, run_addr;
  logic       run_ok;
  logic       prev_ren = 1'b0, prev_busy = 1'b0, prev_done = 1'b0, prev_busy2 = 1'b0;
  logic       prev_done2 = 1'b0;
  int         first_cyc, done_cyc, busy_rises, en_bad;
  logic       done_at_start, err_at_start;
  int         ren2_seen = 0, first2 = -1, done2_cyc = -1;

  task automatic clear_logs();
    wr_cyc.delete(); wr_wen.delete(); wr_dat.delete();
    run_addr_q.delete(); run_len_q.delete(); run_ok_q.delete();
    first_cyc = -1; done_cyc = -1; busy_rises = 0; en_bad = 0;
    done_at_start = 1'b0; err_at_start = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (wen != 8'h00) begin
      wr_cyc.push_back(cyc); wr_wen.push_back(wen); wr_dat.push_back(wdata);
    end
    if (ren) begin
      if (!prev_ren) begin
        run_len = 1; run_addr = int'(addr); run_ok = 1'b1;
      end else begin
        run_len++;
        if (int'(addr) != run_addr) run_ok = 1'b0;
      end
    end else if (prev_ren) begin
      if (int'(addr) != run_addr) run_ok = 1'b0;
      run_addr_q.push_back(run_addr); run_len_q.push_back(run_len); run_ok_q.push_back(run_ok);
    end
    if (busy && !prev_busy) begin
      busy_rises++;
      if (first_cyc < 0) begin
        first_cyc = cyc; done_at_start = done; err_at_start = err;
      end
    end
    if (done && !prev_done && done_cyc < 0) done_cyc = cyc;
    if (ctrl_en !== busy) en_bad++;
    if (ren2) ren2_seen++;
    if (busy2 && !prev_busy2 && first2 < 0) first2 = cyc;
    if (done2 && !prev_done2 && done2_cyc < 0) done2_cyc = cyc;
    prev_ren = ren; prev_busy = busy; prev_done = done;
    prev_busy2 = busy2; prev_done2 = done2;
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic check_load(input vec_t v, input string tag);
    int n;
    logic [63:0] w;
    w = v.words;
    for (int i = 0; i < 200 && done_cyc < 0; i++) tick();
    chk({tag, "_done_seen"}, 32'(done_cyc >= 0), 1);
    chk({tag, "_latency"}, 32'(done_cyc - first_cyc), 49);
    chk({tag, "_busy_rises"}, 32'(busy_rises), 1);
    chk({tag, "_done_clr"}, 32'(done_at_start), 0);
    chk({tag, "_err_clr"}, 32'(err_at_start), 0);
    chk({tag, "_n_writes"}, 32'(wr_wen.size()), 8);
    chk({tag, "_n_runs"}, 32'(run_len_q.size()), 8);
    n = (wr_wen.size() < 8) ? wr_wen.size() : 8;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_wen%0d", tag, k), 32'(wr_wen[k]), 32'(8'h01 << k));
      chk($sformatf("%s_wdata%0d", tag, k), 32'(wr_dat[k]), 32'(w[k*8 +: 8]));
      chk($sformatf("%s_wcyc%0d", tag, k), 32'(wr_cyc[k] - first_cyc), 32'(6*k + 5));
    end
    n = (run_len_q.size() < 8) ? run_len_q.size() : 8;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_raddr%0d", tag, k), 32'(run_addr_q[k]), 32'(k));
      chk($sformatf("%s_rlen%0d", tag, k), 32'(run_len_q[k]), 4);
      chk($sformatf("%s_rstable%0d", tag, k), 32'(run_ok_q[k]), 1);
    end
    chk({tag, "_chk_err"}, 32'(err), 32'(v.exp_err));
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_en_eq_busy"}, 32'(en_bad), 0);
  endtask

  initial begin
    bit found;
    vecs[0] = '{words: {8'h00, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, exp_err: 1'b0};
    vecs[1] = '{words: {8'h5A, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, exp_err: 1'b1};
    vecs[2] = '{words: {8'h5A, 8'hC3, 8'h7E, 8'h81, 8'hF0, 8'h0F, 8'h3C, 8'hA5}, exp_err: 1'b0};
    vecs[3] = '{words: {8'h5B, 8'hC3, 8'h7E, 8'h81, 8'hF0, 8'h0F, 8'h3C, 8'hA5}, exp_err: 1'b1};

    rst_n = 1'b0; load_req = 1'b0; load_req2 = 1'b0;
    cur_words = vecs[0].words; mem2 = vecs[0].words;
    clear_logs();
    repeat (3) tick();
    chk("rst_ren", 32'(ren), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wen", 32'(wen), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(ctrl_en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);

    // Auto-load after reset release, then requested loads for the remaining images.
    clear_logs();
    rst_n = 1'b1;
    check_load(vecs[0], "auto");
    for (int v = 1; v < 4; v++) begin
      repeat (3) tick();
      cur_words = vecs[v].words;
      clear_logs();
      pulse_req();
      check_load(vecs[v], $sformatf("vec%0d", v));
    end

    // Request at cycle 10 of a load is dropped; request 5 cycles after done reloads.
    repeat (3) tick();
    cur_words = vecs[1].words;
    clear_logs();
    pulse_req();
    repeat (9) tick();
    pulse_req();
    check_load(vecs[1], "ign");
    repeat (4) tick();
    chk("ign_no_queue", 32'(busy_rises), 1);
    clear_logs();
    pulse_req();
    check_load(vecs[1], "reload");

    // Reset during the write of word 3.
    repeat (3) tick();
    cur_words = vecs[0].words;
    clear_logs();
    pulse_req();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (wen == 8'h08) found = 1'b1;
    end
    chk("mid_found_w3", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_wen", 32'(wen), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_en", 32'(ctrl_en), 0);
    tick();
    clear_logs();
    rst_n = 1'b1;
    ren2_seen = 0;
    check_load(vecs[0], "restart");

    // AUTO_LOAD = 0 instance: idle for 100+ cycles, then one request loads it.
    repeat (60) tick();
    chk("al0_no_ren", 32'(ren2_seen), 0);
    chk("al0_busy", 32'(busy2), 0);
    chk("al0_done", 32'(done2), 0);
    first2 = -1; done2_cyc = -1;
    load_req2 = 1'b1;
    tick();
    load_req2 = 1'b0;
    for (int i = 0; i < 100 && done2_cyc < 0; i++) tick();
    chk("al0_done_seen", 32'(done2_cyc >= 0), 1);
    chk("al0_latency", 32'(done2_cyc - first2), 49);
    chk("al0_ren_cycles", 32'(ren2_seen), 32);
    chk("al0_err", 32'(err2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
